nthuee_14seg_scroller: RTL and testbench

//  Time-multiplexed scrolling-text driver for an N_DIG-digit 14-segment (+DP) display.
//  - Holds a MSG_LEN-character message of 4-bit codes.
//  - Scans one digit at a time.
//  - Rotates the visible window through the message at a programmable rate.
//  - Sits between the board top level and the 14-seg pins.
//  - Generalises the combinational NTHUEE letter decoder into a sequential, parametrised driver.

---
 rtl/nthuee_14seg_scroller_if.sv | 35 +++
 rtl/nthuee_14seg_scroller.sv | 127 ++++++++++++
 tb/tb_nthuee_14seg_scroller.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/nthuee_14seg_scroller_if.sv
// Bus between the board top level and the scrolling 14-segment driver.
// SCROLL_REVERSE_EN adds the dir control line.
interface nthuee_14seg_scroller_if #(
  parameter int N_DIG   = 4,
  parameter int MSG_LEN = 8
);
  logic                   en;
`ifdef SCROLL_REVERSE_EN
  logic                   dir;
`endif
  logic                   load;
  logic [4*MSG_LEN-1:0]   msg;
  logic [N_DIG-1:0]       digit_sel;
  logic [14:0]            display;
  logic [2:0]             pos;
  logic                   wrap;

  modport master (
    output en,
`ifdef SCROLL_REVERSE_EN
    output dir,
`endif
    output load, msg,
    input  digit_sel, display, pos, wrap
  );

  modport slave (
    input  en,
`ifdef SCROLL_REVERSE_EN
    input  dir,
`endif
    input  load, msg,
    output digit_sel, display, pos, wrap
  );
endinterface

// File: rtl/nthuee_14seg_scroller.sv
// Time-multiplexed scrolling-text driver for an N_DIG-digit 14-segment (+DP) display.
// Define SCROLL_REVERSE_EN to enable reverse scrolling via the dir line.
module nthuee_14seg_scroller #(
  parameter int N_DIG      = 4,
  parameter int MSG_LEN    = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int SCROLL_DIV = 250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nthuee_14seg_scroller_if.slave  bus
);
  localparam int DW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  function automatic logic [4*MSG_LEN-1:0] reset_msg();
    logic [4*MSG_LEN-1:0] r;
    for (int i = 0; i < MSG_LEN; i++) r[4*i +: 4] = (i < 6) ? 4'(i) : 4'hF;
    return r;
  endfunction

  localparam logic [4*MSG_LEN-1:0] MSG_RST = reset_msg();

  function automatic logic [14:0] decode(input logic [3:0] code);
    case (code)
      4'd0:       decode = 15'b100100110111101;
      4'd1:       decode = 15'b011111111011011;
      4'd2:       decode = 15'b100100001111111;
      4'd3:       decode = 15'b100000111111111;
      4'd4, 4'd5: decode = 15'b011000001111111;
      default:    decode = 15'b111111111111111;
    endcase
  endfunction

  logic [SW-1:0]          scan_cnt_q, scan_cnt_d;
  logic [DW-1:0]          d_q, d_d;
  logic [FW-1:0]          frame_cnt_q, frame_cnt_d;
  logic [2:0]             pos_q, pos_d;
  logic                   wrap_q, wrap_d;
  logic [4*MSG_LEN-1:0]   msg_q, msg_d;
  logic [N_DIG-1:0]       digit_sel_q, digit_sel_d;
  logic [14:0]            display_q, display_d;

  logic       scan_tick, frame_tick, step;
  logic [4:0] idx;
  logic [3:0] ch;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    scan_cnt_d  = scan_cnt_q;
    d_d         = d_q;
    frame_cnt_d = frame_cnt_q;
    pos_d       = pos_q;
    wrap_d      = 1'b0;
    msg_d       = msg_q;
    ch          = 4'hF;

    scan_tick  = (scan_cnt_q == SW'(SCAN_DIV - 1));
    frame_tick = scan_tick && (d_q == DW'(N_DIG - 1));
    step       = frame_tick && bus.en && (frame_cnt_q == FW'(SCROLL_DIV - 1));

    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + SW'(1);
    if (scan_tick) d_d = (d_q == DW'(N_DIG - 1)) ? '0 : d_q + DW'(1);

    if (bus.load) begin
      msg_d       = bus.msg;
      pos_d       = '0;
      frame_cnt_d = '0;
    end else begin
      if (frame_tick && bus.en)
        frame_cnt_d = (frame_cnt_q == FW'(SCROLL_DIV - 1)) ? '0 : frame_cnt_q + FW'(1);
      if (step) begin
`ifdef SCROLL_REVERSE_EN
        if (bus.dir) begin
          pos_d  = (pos_q == 3'd0) ? 3'(MSG_LEN - 1) : pos_q - 3'd1;
          wrap_d = (pos_q == 3'd0);
        end else begin
          pos_d  = (pos_q == 3'(MSG_LEN - 1)) ? 3'd0 : pos_q + 3'd1;
          wrap_d = (pos_q == 3'(MSG_LEN - 1));
        end
`else
        pos_d  = (pos_q == 3'(MSG_LEN - 1)) ? 3'd0 : pos_q + 3'd1;
        wrap_d = (pos_q == 3'(MSG_LEN - 1));
`endif
      end
    end

    // Window index wraps once at most: pos < MSG_LEN and d < N_DIG <= MSG_LEN.
    idx = {2'b00, pos_q} + 5'(d_q);
    if (idx >= 5'(MSG_LEN)) idx = idx - 5'(MSG_LEN);
    for (int i = 0; i < MSG_LEN; i++)
      if (int'(idx) == i) ch = msg_q[4*i +: 4];

    digit_sel_d = ~(N_DIG'(1) << d_q);
    display_d   = decode(ch);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      d_q         <= '0;
      frame_cnt_q <= '0;
      pos_q       <= '0;
      wrap_q      <= 1'b0;
      // NOTE: the message store is reset on purpose; the board shows NTHUEE out of reset.
      msg_q       <= MSG_RST;
      digit_sel_q <= '1;
      display_q   <= 15'h7FFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      d_q         <= d_d;
      frame_cnt_q <= frame_cnt_d;
      pos_q       <= pos_d;
      wrap_q      <= wrap_d;
      msg_q       <= msg_d;
      digit_sel_q <= digit_sel_d;
      display_q   <= display_d;
    end
  end

  assign bus.digit_sel = digit_sel_q;
  assign bus.display   = display_q;
  assign bus.pos       = pos_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_nthuee_14seg_scroller.sv
// Randomised self-checking bench for nthuee_14seg_scroller against a cycle-count reference model.
// Build with SCROLL_REVERSE_EN defined to exercise reverse scrolling as well.
module tb_nthuee_14seg_scroller;
  localparam int N_DIG      = 4;
  localparam int MSG_LEN    = 8;
  localparam int SCAN_DIV   = 4;
  localparam int SCROLL_DIV = 2;
  localparam int FRAME      = SCAN_DIV * N_DIG;

  logic clk;
  logic rst_n;

  nthuee_14seg_scroller_if #(.N_DIG(N_DIG), .MSG_LEN(MSG_LEN)) bus ();

  nthuee_14seg_scroller #(
    .N_DIG(N_DIG), .MSG_LEN(MSG_LEN), .SCAN_DIV(SCAN_DIV), .SCROLL_DIV(SCROLL_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: absolute cycle count drives the scan, an enabled-frame tally drives scrolling.
  logic [14:0]      seg_tab [16];
  int               chars_m [MSG_LEN];
  int               cycles_m, frames_en_m, pos_m;
  logic             wrap_m;
  logic [N_DIG-1:0] sel_m;
  logic [14:0]      disp_m;

  task automatic model_reset();
    for (int i = 0; i < MSG_LEN; i++) chars_m[i] = (i < 6) ? i : 15;
    cycles_m    = 0;
    frames_en_m = 0;
    pos_m       = 0;
    wrap_m      = 1'b0;
  endtask

  function automatic bit will_step();
    bit frame_end;
    frame_end = (cycles_m % FRAME) == FRAME - 1;
    return bus.en && frame_end && ((frames_en_m + 1) % SCROLL_DIV == 0);
  endfunction

  task automatic model_edge();
    int dig;
    bit frame_end;
    bit back;
    dig       = (cycles_m / SCAN_DIV) % N_DIG;
    frame_end = (cycles_m % FRAME) == FRAME - 1;
    sel_m     = ~(N_DIG'(1) << dig);
    disp_m    = seg_tab[chars_m[(pos_m + dig) % MSG_LEN]];
    wrap_m    = 1'b0;
    back      = 1'b0;
`ifdef SCROLL_REVERSE_EN
    back      = bus.dir;
`endif
    if (bus.load) begin
      for (int i = 0; i < MSG_LEN; i++) chars_m[i] = int'(bus.msg[4*i +: 4]);
      pos_m       = 0;
      frames_en_m = 0;
    end else if (bus.en && frame_end) begin
      frames_en_m++;
      if (frames_en_m == SCROLL_DIV) begin
        frames_en_m = 0;
        if (back) begin
          wrap_m = (pos_m == 0);
          pos_m  = (pos_m + MSG_LEN - 1) % MSG_LEN;
        end else begin
          pos_m  = (pos_m + 1) % MSG_LEN;
          wrap_m = (pos_m == 0);
        end
      end
    end
    cycles_m++;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("digit_sel", 32'(bus.digit_sel), 32'(sel_m));
    check("display",   32'(bus.display),   32'(disp_m));
    check("pos",       32'(bus.pos),       32'(pos_m));
    check("wrap",      32'(bus.wrap),      32'(wrap_m));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_display"},   32'(bus.display),   32'h7FFF);
    check({tag, "_digit_sel"}, 32'(bus.digit_sel), 32'(4'b1111));
    check({tag, "_pos"},       32'(bus.pos),       32'd0);
    check({tag, "_wrap"},      32'(bus.wrap),      32'd0);
  endtask

  task automatic run_to_pos(input int target, input string tag);
    int n;
    n = 0;
    while (pos_m != target && n < 20 * FRAME * SCROLL_DIV) begin
      cycle();
      n++;
    end
    if (pos_m != target) check(tag, 32'(pos_m), 32'(target));
  endtask

  initial begin
    int n;
    int wraps;
    for (int i = 0; i < 16; i++) seg_tab[i] = 15'b111111111111111;
    seg_tab[0] = 15'b100100110111101;
    seg_tab[1] = 15'b011111111011011;
    seg_tab[2] = 15'b100100001111111;
    seg_tab[3] = 15'b100000111111111;
    seg_tab[4] = 15'b011000001111111;
    seg_tab[5] = 15'b011000001111111;

    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.load = 1'b0;
    bus.msg  = '0;
`ifdef SCROLL_REVERSE_EN
    bus.dir  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    rst_n = 1'b1;
    model_reset();
    cycle();
    check("first_sel", 32'(bus.digit_sel), 32'(4'b1110));
    check("first_disp", 32'(bus.display), 32'(15'b100100110111101));

    // Frozen scan: the window must never move.
    repeat (4 * FRAME) cycle();
    check("frozen_pos", 32'(bus.pos), 32'd0);

    // Forward scroll through a full wrap; count wrap pulses seen.
    bus.en = 1'b1;
    wraps  = 0;
    for (int i = 0; i < MSG_LEN * SCROLL_DIV * FRAME; i++) begin
      cycle();
      if (bus.wrap) wraps++;
    end
    check("wrap_count", 32'(wraps), 32'd1);

    // Load all-E exactly on a step cycle: load wins, no increment, no wrap.
    n = 0;
    while (!will_step() && n < 4 * FRAME * SCROLL_DIV) begin
      cycle();
      n++;
    end
    check("step_found", 32'(will_step()), 32'd1);
    bus.load = 1'b1;
    bus.msg  = {MSG_LEN{4'h4}};
    cycle();
    bus.load = 1'b0;
    check("load_pos", 32'(bus.pos), 32'd0);
    check("load_wrap", 32'(bus.wrap), 32'd0);
    repeat (FRAME) cycle();
    check("load_disp", 32'(bus.display), 32'(15'b011000001111111));

    // Freeze mid-rotation, then resume.
    run_to_pos(3, "reach_pos3");
    bus.en = 1'b0;
    repeat (100) cycle();
    check("freeze_pos", 32'(bus.pos), 32'd3);
    bus.en = 1'b1;
    repeat (2 * FRAME * SCROLL_DIV) cycle();

`ifdef SCROLL_REVERSE_EN
    // Reverse from pos 0 lands on the last (blank) character with a wrap pulse.
    bus.load = 1'b1;
    bus.msg  = {4'hF, 4'hF, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    cycle();
    bus.load = 1'b0;
    bus.dir  = 1'b1;
    wraps = 0;
    repeat (FRAME * SCROLL_DIV + 1) begin
      cycle();
      if (bus.wrap) wraps++;
    end
    check("rev_pos", 32'(bus.pos), 32'(MSG_LEN - 1));
    check("rev_wraps", 32'(wraps), 32'd1);
`endif

    // Randomised traffic: en mostly on, rare loads of random messages.
    for (int i = 0; i < 3000; i++) begin
      bus.en   = ($urandom_range(0, 9) != 0);
      bus.load = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < MSG_LEN; c++) bus.msg[4*c +: 4] = 4'($urandom_range(0, 15));
`ifdef SCROLL_REVERSE_EN
      if ($urandom_range(0, 99) == 0) bus.dir = ~bus.dir;
`endif
      cycle();
    end
    bus.load = 1'b0;

    // Asynchronous reset mid-operation blanks outputs without waiting for an edge.
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n  = 1'b1;
    bus.en = 1'b1;
`ifdef SCROLL_REVERSE_EN
    bus.dir = 1'b0;
`endif
    model_reset();
    repeat (3 * FRAME * SCROLL_DIV) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
